ball_motion: RTL and testbench

Ball position and bounce engine for the paddle game: sits directly downstream of the paddle block, consuming its `x_pos` as `paddle_x`, and produces the ball coordinates consumed by the renderer and the score/lives logic. Moves the ball one pixel per axis per movement tick. Reflects off the side and top walls and the paddle. Reports paddle hits and misses as single-cycle pulses.

---
 rtl/game_pkg.sv | 23 ++
 rtl/move_tick.sv | 37 +++
 rtl/ball_motion.sv | 149 ++++++++++++++
 tb/tb_ball_motion.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared playfield geometry, ball FSM states and direction encodings.
// No logic: constants and types only.
// Imported by the paddle and ball blocks so screen geometry stays consistent.
package game_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int BALL_SIZE = 8;
    localparam int PADDLE_W  = 64;
    localparam int PADDLE_Y  = 440;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        MISS = 2'd2
    } ball_state_t;

    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic DIR_UP    = 1'b0;

endpackage

// File: rtl/move_tick.sv
// Movement prescaler: pulses tick_o once every DIV enabled cycles.
// Latency: tick_o is combinational from the count; the count is registered.
// Backpressure: en_i low freezes the count; clr_i forces it back to zero.
module move_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Ball position/bounce engine: serves from the paddle, reflects off walls and paddle.
// Latency: all outputs registered; a tick's effect shows one cycle after the tick.
// Backpressure: pause freezes state, position, pulses and the prescaler.
module ball_motion #(
    parameter int SCREEN_W  = game_pkg::SCREEN_W,
    parameter int SCREEN_H  = game_pkg::SCREEN_H,
    parameter int BALL_SIZE = game_pkg::BALL_SIZE,
    parameter int PADDLE_W  = game_pkg::PADDLE_W,
    parameter int PADDLE_Y  = game_pkg::PADDLE_Y,
    parameter int MOVE_DIV  = 250000,
    parameter int MISS_HOLD = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pause,
    input  logic       launch,
    input  logic [9:0] paddle_x,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       ball_active,
    output logic       hit_pulse,
    output logic       miss_pulse
);

    import game_pkg::*;

    localparam int HW = (MISS_HOLD > 1) ? $clog2(MISS_HOLD) : 1;

    ball_state_t   state_q, state_d;
    logic          dx_q, dx_d, dy_q, dy_d;
    logic [9:0]    bx_q, bx_d, by_q, by_d;
    logic          hit_q, hit_d, miss_q, miss_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          tick;
    logic [9:0]    rest_x, rest_y;
    logic [10:0]   x11, y11, px11;
    logic          over_paddle, left_half;

    move_tick #(.DIV(MOVE_DIV)) u_move_tick (
        .clk    (clk),
        .reset  (reset),
        .en_i   (!pause),
        .clr_i  (state_q == IDLE),
        .tick_o (tick)
    );

    assign rest_x = paddle_x + 10'(PADDLE_W / 2 - BALL_SIZE / 2);
    assign rest_y = 10'(PADDLE_Y - BALL_SIZE);

    // Widen to 11 bits so edge sums near the right of the field cannot wrap.
    assign x11  = {1'b0, bx_q};
    assign y11  = {1'b0, by_q};
    assign px11 = {1'b0, paddle_x};

    assign over_paddle = (x11 + 11'(BALL_SIZE) > px11) && (x11 < px11 + 11'(PADDLE_W));
    assign left_half   = (x11 + 11'(BALL_SIZE / 2)) < (px11 + 11'(PADDLE_W / 2));

    always_comb begin
        state_d = state_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        bx_d    = bx_q;
        by_d    = by_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        hold_d  = hold_q;
        if (!pause) begin
            hit_d  = 1'b0;
            miss_d = 1'b0;
            case (state_q)
                IDLE: begin
                    bx_d = rest_x;
                    by_d = rest_y;
                    if (launch) begin
                        state_d = PLAY;
                        dx_d    = DIR_RIGHT;
                        dy_d    = DIR_UP;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        if (dx_q == DIR_RIGHT && x11 == 11'(SCREEN_W - BALL_SIZE)) begin
                            dx_d = DIR_LEFT;
                        end else if (dx_q == DIR_LEFT && bx_q == 10'd0) begin
                            dx_d = DIR_RIGHT;
                        end
                        if (dy_q == DIR_UP && by_q == 10'd0) begin
                            dy_d = DIR_DOWN;
                        end else if (dy_q == DIR_DOWN && y11 + 11'(BALL_SIZE) == 11'(PADDLE_Y)
                                     && over_paddle) begin
                            dy_d  = DIR_UP;
                            hit_d = 1'b1;
                            dx_d  = left_half ? DIR_LEFT : DIR_RIGHT;
                        end else if (dy_q == DIR_DOWN && y11 == 11'(SCREEN_H - BALL_SIZE)) begin
                            state_d = MISS;
                            miss_d  = 1'b1;
                            hold_d  = '0;
                        end
                        if (state_d == PLAY) begin
                            bx_d = (dx_d == DIR_RIGHT) ? bx_q + 10'd1 : bx_q - 10'd1;
                            by_d = (dy_d == DIR_DOWN)  ? by_q + 10'd1 : by_q - 10'd1;
                        end
                    end
                end
                MISS: begin
                    if (tick) begin
                        if (hold_q == HW'(MISS_HOLD - 1)) begin
                            state_d = IDLE;
                            bx_d    = rest_x;
                            by_d    = rest_y;
                        end else begin
                            hold_d = hold_q + HW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dx_q    <= DIR_RIGHT;
            dy_q    <= DIR_UP;
            bx_q    <= rest_x;
            by_q    <= rest_y;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            hold_q  <= hold_d;
        end
    end

    assign ball_x      = bx_q;
    assign ball_y      = by_q;
    assign ball_active = (state_q == PLAY);
    assign hit_pulse   = hit_q;
    assign miss_pulse  = miss_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: a trajectory model checked every cycle,
// plus hand-computed positions at serve, walls, corner, paddle hits, miss, pause and reset.
module tb_ball_motion;

    localparam int MOVE_DIV  = 1;
    localparam int MISS_HOLD = 4;
    localparam int M_IDLE = 0, M_PLAY = 1, M_MISS = 2;

    logic       clk = 1'b0;
    logic       reset, pause, launch;
    logic [9:0] paddle_x;
    logic [9:0] ball_x, ball_y;
    logic       ball_active, hit_pulse, miss_pulse;

    int checks = 0;
    int errors = 0;

    ball_motion #(.MOVE_DIV(MOVE_DIV), .MISS_HOLD(MISS_HOLD)) dut (
        .clk         (clk),
        .reset       (reset),
        .pause       (pause),
        .launch      (launch),
        .paddle_x    (paddle_x),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .ball_active (ball_active),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Trajectory model: integer position and signed unit velocity.
    int mode, mx, my, vx, vy, pre, remaining;
    bit m_hit, m_miss, mvalid = 1'b0;

    always @(posedge clk) begin : model
        bit tk;
        bit missed;
        int px;
        px = int'(paddle_x);
        if (reset) begin
            mode = M_IDLE; mx = px + 28; my = 432; vx = 1; vy = -1;
            pre = 0; m_hit = 0; m_miss = 0; remaining = 0; mvalid = 1'b1;
        end else if (!pause) begin
            m_hit = 0; m_miss = 0; tk = 0;
            if (mode == M_IDLE) pre = 0;
            else begin
                tk  = (pre == MOVE_DIV - 1);
                pre = tk ? 0 : pre + 1;
            end
            if (mode == M_IDLE) begin
                mx = px + 28; my = 432;
                if (launch) begin mode = M_PLAY; vx = 1; vy = -1; end
            end else if (mode == M_PLAY && tk) begin
                missed = 0;
                if (mx + vx < 0 || mx + vx > 632) vx = -vx;
                if (vy < 0 && my == 0) vy = 1;
                else if (vy > 0 && my + 8 == 440 && mx + 8 > px && mx < px + 64) begin
                    vy = -1; m_hit = 1;
                    vx = (2 * mx + 8 < 2 * px + 64) ? -1 : 1;
                end else if (vy > 0 && my == 472) begin
                    missed = 1; m_miss = 1; mode = M_MISS; remaining = MISS_HOLD;
                end
                if (!missed) begin mx += vx; my += vy; end
            end else if (mode == M_MISS && tk) begin
                remaining--;
                if (remaining == 0) begin mode = M_IDLE; mx = px + 28; my = 432; end
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model ball_x", int'(ball_x), mx);
            chk("model ball_y", int'(ball_y), my);
            chk("model ball_active", int'(ball_active), (mode == M_PLAY) ? 1 : 0);
            chk("model hit_pulse", int'(hit_pulse), int'(m_hit));
            chk("model miss_pulse", int'(miss_pulse), int'(m_miss));
        end
    end

    // sel: 0 ball_x==v, 1 ball_y==v, 2 hit_pulse, 3 miss_pulse
    task automatic wait_for(input string nm, input int sel, input int v);
        int n = 0;
        bit done = 0;
        while (!done && n < 3000) begin
            case (sel)
                0: done = (int'(ball_x) == v);
                1: done = (int'(ball_y) == v);
                2: done = hit_pulse;
                default: done = miss_pulse;
            endcase
            if (!done) begin @(negedge clk); n++; end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s: event not seen within 3000 cycles", nm);
        end
    endtask

    task automatic chk_pos(input string nm, input int ex, input int ey);
        chk({nm, " x"}, int'(ball_x), ex);
        chk({nm, " y"}, int'(ball_y), ey);
    endtask

    initial begin
        reset = 1'b1; pause = 1'b0; launch = 1'b0; paddle_x = 10'd288;
        repeat (3) @(negedge clk);
        chk_pos("reset rest", 316, 432);
        chk("reset active", int'(ball_active), 0);
        chk("reset hit", int'(hit_pulse), 0);
        chk("reset miss", int'(miss_pulse), 0);

        reset = 1'b0; paddle_x = 10'd300;
        @(negedge clk); chk("track x", int'(ball_x), 328);
        paddle_x = 10'd288;
        @(negedge clk); chk("track back x", int'(ball_x), 316);

        pause = 1'b1; launch = 1'b1;
        repeat (3) @(negedge clk);
        chk("paused launch ignored", int'(ball_active), 0);
        pause = 1'b0;
        @(negedge clk);
        chk("launch active", int'(ball_active), 1);
        chk_pos("launch pos", 316, 432);
        launch = 1'b0; paddle_x = 10'd60;
        @(negedge clk); chk_pos("first tick", 317, 431);

        wait_for("right wall", 0, 632);
        chk("right wall y", int'(ball_y), 116);
        @(negedge clk); chk_pos("right wall bounce", 631, 115);

        wait_for("top wall", 1, 0);
        chk("top wall x", int'(ball_x), 516);
        @(negedge clk); chk_pos("top wall bounce", 515, 1);

        wait_for("hit left", 2, 0);
        chk_pos("hit left pos", 83, 431);
        paddle_x = 10'd440;
        @(negedge clk);
        chk("hit left pulse width", int'(hit_pulse), 0);
        chk_pos("hit left goes left", 82, 430);

        wait_for("hit right", 2, 0);
        chk_pos("hit right pos", 485, 431);
        paddle_x = 10'd0;
        @(negedge clk);
        chk("hit right pulse width", int'(hit_pulse), 0);
        chk_pos("hit right goes right", 486, 430);

        wait_for("miss", 3, 0);
        chk_pos("miss frozen", 124, 472);
        chk("miss active", int'(ball_active), 0);
        repeat (3) @(negedge clk);
        chk_pos("miss hold", 124, 472);
        chk("miss pulse width", int'(miss_pulse), 0);
        @(negedge clk);
        chk_pos("miss to idle", 28, 432);
        chk("idle active", int'(ball_active), 0);

        paddle_x = 10'd172;
        @(negedge clk); chk("idle track x", int'(ball_x), 200);
        launch = 1'b1;
        @(negedge clk); launch = 1'b0;
        chk_pos("relaunch pos", 200, 432);
        repeat (4) @(negedge clk);
        chk_pos("before pause", 204, 428);
        pause = 1'b1;
        repeat (10) @(negedge clk);
        chk_pos("during pause", 204, 428);
        chk("pause active", int'(ball_active), 1);
        pause = 1'b0;
        @(negedge clk); chk_pos("after pause", 205, 427);

        wait_for("corner", 0, 632);
        chk("corner y", int'(ball_y), 0);
        @(negedge clk); chk_pos("corner bounce", 631, 1);
        repeat (5) @(negedge clk);

        reset = 1'b1;
        @(negedge clk);
        chk_pos("mid-play reset", 200, 432);
        chk("mid-play reset active", int'(ball_active), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
